// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg: shared constants, types and helpers for the data-memory
// arbiter slice (dm_arbiter, dm_arbiter_pick, dm_arbiter_if).
package dm_arbiter_pkg;

   localparam logic        OWN_CPU            = 1'b0;
   localparam logic        OWN_DMA            = 1'b1;
   localparam int          RUN_CNT_W          = 4;
   localparam int          DM_ADDR_HI         = 12;   // memory spans 4 KB
   localparam logic [31:0] DEFAULT_DMA_PC_TAG = 32'hFFFF_FFFF;

   typedef logic [RUN_CNT_W-1:0] run_cnt_t;

   // One access as it appears on the memory side once a requester wins.
   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] pc;
   } dm_acc_t;

   // Saturating increment of the burst counter.
   function automatic run_cnt_t run_cnt_inc(input run_cnt_t c);
      return (c == '1) ? c : c + run_cnt_t'(1);
   endfunction

   // Address outside the word-aligned 4 KB memory window.
   function automatic logic addr_bad(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a[31:DM_ADDR_HI] != '0);
   endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: CPU MEM-stage port, DMA port and data-memory port of the
// arbiter. slave = arbiter view, master = view of the surrounding system.
interface dm_arbiter_if;

   // CPU MEM stage
   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_pc;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;

   // DMA / debug master
   logic        dma_req;
   logic        dma_we;
   logic [31:0] dma_addr;
   logic [31:0] dma_wdata;
   logic        dma_gnt;
   logic [31:0] dma_rdata;

   // data memory
   logic        mem_MemRead;
   logic        mem_MemWrite;
   logic [31:0] mem_Addr;
   logic [31:0] mem_Wdata;
   logic [31:0] mem_pc;
   logic [31:0] mem_Rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_pc,
      output cpu_rdata, cpu_stall,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      output dma_gnt, dma_rdata,
      output mem_MemRead, mem_MemWrite, mem_Addr, mem_Wdata, mem_pc,
      input  mem_Rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_pc,
      input  cpu_rdata, cpu_stall,
      output dma_req, dma_we, dma_addr, dma_wdata,
      input  dma_gnt, dma_rdata,
      input  mem_MemRead, mem_MemWrite, mem_Addr, mem_Wdata, mem_pc,
      output mem_Rdata
   );

endinterface

// File: rtl/dm_arbiter_pick.sv
// dm_arbiter_pick: combinational round-robin grant picker with burst limit.
// The current owner keeps the memory while run_cnt < MAX_BURST; a lone
// requester always wins.
module dm_arbiter_pick
   import dm_arbiter_pkg::*;
#(
   parameter int MAX_BURST = 4
) (
   input  logic     cpu_req,
   input  logic     dma_req,
   input  logic     owner,
   input  run_cnt_t run_cnt,
   output logic     cpu_granted,
   output logic     dma_granted
);

   localparam run_cnt_t MAX_CNT = run_cnt_t'(MAX_BURST);

   logic burst_ok;
   logic cpu_wins_tie;

   // On contention the CPU wins when it owns and is under budget, or when the
   // DMA owns and has used up its budget.
   always_comb begin
      burst_ok     = (run_cnt < MAX_CNT);
      cpu_wins_tie = ((owner == OWN_CPU) == burst_ok);
      cpu_granted  = cpu_req & (~dma_req | cpu_wins_tie);
      dma_granted  = dma_req & (~cpu_req | ~cpu_wins_tie);
   end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-port data memory between the CPU MEM stage
// and a DMA/debug master. Zero added latency: the winner's access is muxed
// straight onto the memory port in its grant cycle.
// Optional: DM_ARBITER_ADDR_CHECK_EN adds a sticky err output and suppresses
// memory access for misaligned or out-of-window addresses.
module dm_arbiter
   import dm_arbiter_pkg::*;
#(
   parameter int          MAX_BURST  = 4,
   parameter logic [31:0] DMA_PC_TAG = DEFAULT_DMA_PC_TAG
) (
   input  logic        arb_clk,
   input  logic        arb_reset,
   dm_arbiter_if.slave bus
`ifdef DM_ARBITER_ADDR_CHECK_EN
   ,
   output logic        err
`endif
);

   logic     owner;
   run_cnt_t run_cnt;
   logic     cpu_req_v, dma_req_v;
   logic     cpu_granted, dma_granted, granted;
   logic     blk;
   dm_acc_t  win;

   // Reset masks both requests so nothing is granted while it is held.
   assign cpu_req_v = bus.cpu_req & ~arb_reset;
   assign dma_req_v = bus.dma_req & ~arb_reset;

   dm_arbiter_pick #(.MAX_BURST(MAX_BURST)) u_pick (
      .cpu_req     (cpu_req_v),
      .dma_req     (dma_req_v),
      .owner       (owner),
      .run_cnt     (run_cnt),
      .cpu_granted (cpu_granted),
      .dma_granted (dma_granted)
   );

   assign granted = cpu_granted | dma_granted;

   // Select the winning requester's access.
   always_comb begin
      win = '0;
      if (dma_granted) begin
         win.we    = bus.dma_we;
         win.addr  = bus.dma_addr;
         win.wdata = bus.dma_wdata;
         win.pc    = DMA_PC_TAG;
      end else if (cpu_granted) begin
         win.we    = bus.cpu_we;
         win.addr  = bus.cpu_addr;
         win.wdata = bus.cpu_wdata;
         win.pc    = bus.cpu_pc;
      end
   end

`ifdef DM_ARBITER_ADDR_CHECK_EN
   assign blk = granted & addr_bad(win.addr);
`else
   assign blk = 1'b0;
`endif

   // Memory port: all zero unless someone is granted; bad addresses are
   // granted (to release the requester) but never touch memory.
   always_comb begin
      bus.mem_MemRead  = granted & ~win.we & ~blk;
      bus.mem_MemWrite = granted &  win.we & ~blk;
      bus.mem_Addr     = win.addr;
      bus.mem_Wdata    = win.wdata;
      bus.mem_pc       = win.pc;
   end

   // Requester-side responses; read data is valid only in the grant cycle.
   always_comb begin
      bus.cpu_rdata = bus.mem_Rdata;
      bus.dma_rdata = bus.mem_Rdata;
      bus.cpu_stall = cpu_req_v & ~cpu_granted;
      bus.dma_gnt   = dma_granted;
   end

   // Owner / burst counter update: extend the run or hand over ownership.
   always_ff @(posedge arb_clk) begin
      if (arb_reset) begin
         owner   <= OWN_CPU;
         run_cnt <= '0;
      end else if (granted) begin
         if (dma_granted == owner) begin
            run_cnt <= run_cnt_inc(run_cnt);
         end else begin
            owner   <= dma_granted;
            run_cnt <= run_cnt_t'(1);
         end
      end
   end

`ifdef DM_ARBITER_ADDR_CHECK_EN
   // Sticky address error, cleared only by reset.
   always_ff @(posedge arb_clk) begin
      if (arb_reset) err <= 1'b0;
      else if (blk)  err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: scoreboard bench for dm_arbiter. The stimulus process
// predicts each cycle's outputs from a behavioural model (last winner and
// streak length, plus a shadow memory) and queues them; a monitor compares
// the DUT on the falling edge. Define DM_ARBITER_ADDR_CHECK_EN to cover err.
module tb_dm_arbiter;

   localparam int MAX_BURST = 4;
   localparam logic [31:0] TAG = 32'hFFFF_FFFF;

   typedef struct {
      logic        stall, gnt, rd, wr, err;
      logic [31:0] addr, wdata, pc;
      logic        chk_crd, chk_drd;
      logic [31:0] rdv;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic err;

   dm_arbiter_if bus();

`ifdef DM_ARBITER_ADDR_CHECK_EN
   dm_arbiter #(.MAX_BURST(MAX_BURST), .DMA_PC_TAG(TAG)) dut (
      .arb_clk(clk), .arb_reset(rst), .bus(bus), .err(err));
`else
   dm_arbiter #(.MAX_BURST(MAX_BURST), .DMA_PC_TAG(TAG)) dut (
      .arb_clk(clk), .arb_reset(rst), .bus(bus));
   assign err = 1'b0;
`endif

   always #5 clk = ~clk;

   // Environment data memory (combinational read, write at the edge).
   logic [31:0] tb_mem [0:1023];
   assign bus.mem_Rdata = tb_mem[bus.mem_Addr[11:2]];
   always @(posedge clk) if (bus.mem_MemWrite) tb_mem[bus.mem_Addr[11:2]] <= bus.mem_Wdata;

   exp_t  q[$];
   string tq[$];
   int    n_chk = 0;
   int    n_fail = 0;

   // Model state: who used the memory last, how many times in a row.
   int          last_win = 0;
   int          streak = 0;
   logic        err_m = 1'b0;
   logic [31:0] shadow [int];
   bit          cpu_hold = 0, dma_hold = 0;

   function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   function automatic logic [31:0] shadow_rd(logic [31:0] a);
      int k = int'(a[11:2]);
      return shadow.exists(k) ? shadow[k] : 32'h0;
   endfunction

   function automatic logic [31:0] rand_addr();
`ifdef DM_ARBITER_ADDR_CHECK_EN
      if ($urandom_range(0, 7) == 0) return $urandom;
`endif
      return 32'($urandom_range(0, 63)) << 2;
   endfunction

   // Predict this cycle from the current inputs, queue it, advance the model.
   task automatic issue(input string tag, input int want_dgnt);
      exp_t        e;
      int          w;
      logic        we, bad;
      logic [31:0] a, wd, pc;
      w = -1;
      if (!rst) begin
         if (bus.cpu_req && bus.dma_req)
            w = (streak < MAX_BURST) ? last_win : 1 - last_win;
         else if (bus.cpu_req) w = 0;
         else if (bus.dma_req) w = 1;
      end
      we = 0; a = 0; wd = 0; pc = 0; bad = 0;
      if (w == 0) begin we = bus.cpu_we; a = bus.cpu_addr; wd = bus.cpu_wdata; pc = bus.cpu_pc; end
      if (w == 1) begin we = bus.dma_we; a = bus.dma_addr; wd = bus.dma_wdata; pc = TAG; end
`ifdef DM_ARBITER_ADDR_CHECK_EN
      bad = (w >= 0) && (a[1:0] != 0 || a[31:12] != 0);
`endif
      e.stall   = bus.cpu_req && !rst && w != 0;
      e.gnt     = (w == 1);
      e.rd      = (w >= 0) && !we && !bad;
      e.wr      = (w >= 0) && we && !bad;
      e.addr    = a;
      e.wdata   = wd;
      e.pc      = pc;
      e.err     = err_m;
      e.chk_crd = (w == 0) && e.rd;
      e.chk_drd = (w == 1) && e.rd;
      e.rdv     = shadow_rd(a);
      q.push_back(e);
      tq.push_back(tag);
      if (rst) begin
         last_win = 0; streak = 0; err_m = 0;
      end else if (w >= 0) begin
         if (w == last_win) streak = (streak >= 15) ? 15 : streak + 1;
         else begin last_win = w; streak = 1; end
         if (e.wr) shadow[int'(a[11:2])] = wd;
         if (bad) err_m = 1;
      end
      cpu_hold = bus.cpu_req && e.stall;
      dma_hold = bus.dma_req && w != 1;
      if (want_dgnt >= 0) begin
         #2;
         check({tag, "_pattern"}, {31'h0, bus.dma_gnt}, want_dgnt[31:0]);
      end
      @(posedge clk); #1;
   endtask

   task automatic set_cpu(logic req, logic we, logic [31:0] a, logic [31:0] d);
      bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
      bus.cpu_pc = 32'h0000_1000 + a;
   endtask

   task automatic set_dma(logic req, logic we, logic [31:0] a, logic [31:0] d);
      bus.dma_req = req; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = d;
   endtask

   // Monitor: compare every queued expectation against the DUT mid-cycle.
   initial begin
      exp_t  e;
      string t;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            t = tq.pop_front();
            check({t, "_stall"}, {31'h0, bus.cpu_stall},    {31'h0, e.stall});
            check({t, "_dgnt"},  {31'h0, bus.dma_gnt},      {31'h0, e.gnt});
            check({t, "_rd"},    {31'h0, bus.mem_MemRead},  {31'h0, e.rd});
            check({t, "_wr"},    {31'h0, bus.mem_MemWrite}, {31'h0, e.wr});
            check({t, "_addr"},  bus.mem_Addr,  e.addr);
            check({t, "_wdata"}, bus.mem_Wdata, e.wdata);
            check({t, "_pc"},    bus.mem_pc,    e.pc);
            if (e.chk_crd) check({t, "_crdata"}, bus.cpu_rdata, e.rdv);
            if (e.chk_drd) check({t, "_drdata"}, bus.dma_rdata, e.rdv);
`ifdef DM_ARBITER_ADDR_CHECK_EN
            check({t, "_err"}, {31'h0, err}, {31'h0, e.err});
`endif
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 1024; i++) tb_mem[i] = 32'h0;
      rst = 1;
      set_cpu(1, 1, 32'h10, 32'h1111_1111);
      set_dma(1, 1, 32'h14, 32'h2222_2222);
      @(posedge clk); #1;

      // reset: no grants, no stall, memory quiet
      issue("reset", 0);
      issue("reset", 0);
      rst = 0;

      // lone CPU store, then load it back
      set_dma(0, 0, 0, 0);
      set_cpu(1, 1, 32'h10, 32'hDEAD_BEEF);
      issue("cpu_store", 0);
      set_cpu(0, 0, 0, 0);
      issue("idle1", 0);
      set_cpu(1, 0, 32'h10, 32'h0);
      issue("cpu_load", 0);

      // both requesting continuously: CPU x4, DMA x4, CPU x4
      rst = 1; set_cpu(0, 0, 0, 0); issue("rst2", 0); rst = 0;
      set_cpu(1, 0, 32'h10, 32'h0);
      set_dma(1, 1, 32'h40, 32'hA5A5_0001);
      for (int i = 0; i < 12; i++) issue("burst", (i / 4) % 2);

      // DMA owner: DMA write 0x55 and CPU read of 0x20 together
      rst = 1; issue("rst3", -1); rst = 0;
      set_cpu(0, 0, 0, 0);
      set_dma(1, 1, 32'h80, 32'h1);
      issue("dma_own", 1);
      set_dma(1, 1, 32'h20, 32'h55);
      set_cpu(1, 0, 32'h20, 32'h0);
      issue("dma_first", 1);
      set_dma(0, 0, 0, 0);
      issue("cpu_after", 0);

      // reset mid-burst after 2 DMA grants
      set_cpu(1, 0, 32'h20, 32'h0);
      set_dma(1, 1, 32'h24, 32'h77);
      rst = 1; issue("rst4", 0); rst = 0;
      for (int i = 0; i < 6; i++) issue("pre_rst", (i >= 4) ? 1 : 0);
      rst = 1; issue("mid_rst", 0); rst = 0;
      for (int i = 0; i < 5; i++) issue("post_rst", (i == 4) ? 1 : 0);

      // idle for 5 cycles, state must hold
      set_cpu(0, 0, 0, 0); set_dma(0, 0, 0, 0);
      for (int i = 0; i < 5; i++) issue("idle", 0);
      set_cpu(1, 0, 32'h24, 32'h0); set_dma(1, 0, 32'h28, 32'h0);
      for (int i = 0; i < 3; i++) issue("resume", -1);
      set_cpu(0, 0, 0, 0); set_dma(0, 0, 0, 0);
      issue("idle2", 0);

`ifdef DM_ARBITER_ADDR_CHECK_EN
      // bad address: granted, no memory access, sticky err
      set_cpu(1, 1, 32'h1003, 32'h99);
      issue("bad_addr", 0);
      set_cpu(0, 0, 0, 0);
      issue("err_hold", 0);
      issue("err_hold", 0);
      rst = 1; issue("err_rst", 0); rst = 0;
      issue("err_clr", 0);
`endif

      // randomized traffic obeying the hold rules
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 49) == 0);
         if (!cpu_hold)
            set_cpu(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), rand_addr(), $urandom);
         if (!dma_hold)
            set_dma(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), rand_addr(), $urandom);
         issue("rand", -1);
      end
      rst = 0;
      set_cpu(0, 0, 0, 0); set_dma(0, 0, 0, 0);
      repeat (3) @(posedge clk);
      check("queue_drain", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
